// File: rtl/aclk_time_entry.sv
// aclk_time_entry: keypad time/alarm entry sequencer for the alarm clock.
// Collects four BCD digits (HH:MM), validates each one and loads it on commit.
// Ports:
//   clk, reset (async, active-low)
//   start, mode       - begin an entry; mode 0 = time, 1 = alarm
//   key_valid, key_digit - keypad strobe and BCD digit
//   commit, cancel    - load or abandon the staged entry
//   H_in1..M_in0      - committed digits (hold between loads)
//   LD_time, LD_alarm - one-cycle load strobes
//   busy, digit_idx, key_err - status
module aclk_time_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       commit,
  input  logic       cancel,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       busy,
  output logic [1:0] digit_idx,
  output logic       key_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    READY = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  stg_q, stg_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       h1_q, h1_d;
  logic [3:0]       h0_q, h0_d;
  logic [3:0]       m1_q, m1_d;
  logic [3:0]       m0_q, m0_d;

  logic             acc;
  logic             tmo;

  // Digit acceptance for the current position; H0 is limited to 0..3
  // once the staged hour tens digit is 2 (hours 20..23).
  always_comb begin
    acc = 1'b0;
    unique case (idx_q)
      2'd0: acc = (key_digit <= 4'd2);
      2'd1: acc = (stg_q[0] == 4'd2) ? (key_digit <= 4'd3)
                                     : (key_digit <= 4'd9);
      2'd2: acc = (key_digit <= 4'd5);
      2'd3: acc = (key_digit <= 4'd9);
      default: acc = 1'b0;
    endcase
  end

  // Counter value TMAX marks the TIMEOUT_CYCLES-th quiet cycle.
  assign tmo = (cnt_q == TMAX);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ENTRY;
          mode_d  = mode;
          idx_d   = 2'd0;
          stg_d   = '0;
          cnt_d   = '0;
        end
      end
      ENTRY: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (key_valid) begin
          cnt_d = '0;
          if (acc) begin
            stg_d[idx_q] = key_digit;
            idx_d        = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = READY;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      READY: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (commit) begin
          state_d = LOAD;
          cnt_d   = '0;
          h1_d    = stg_q[0][1:0];
          h0_d    = stg_q[1];
          m1_d    = stg_q[2];
          m0_d    = stg_q[3];
        end else if (key_valid) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      idx_q   <= 2'd0;
      stg_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      h1_q    <= 2'd0;
      h0_q    <= 4'd0;
      m1_q    <= 4'd0;
      m0_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
    end
  end

  assign H_in1     = h1_q;
  assign H_in0     = h0_q;
  assign M_in1     = m1_q;
  assign M_in0     = m0_q;
  assign LD_time   = (state_q == LOAD) && !mode_q;
  assign LD_alarm  = (state_q == LOAD) &&  mode_q;
  assign busy      = (state_q != IDLE);
  assign digit_idx = (state_q == ENTRY) ? idx_q : 2'd0;
  assign key_err   = err_q;

endmodule

// File: doc/aclk_time_entry.md
ACLK_TIME_ENTRY -- requirements
Module: aclk_time_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: number of cycles without a key event after which a partial entry is aborted; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin an entry sequence.
REQ-005 mode  input  1  sampled with start; 0 = set time, 1 = set alarm.
REQ-006 key_valid  input  1  one-cycle strobe; key_digit valid this cycle.
REQ-007 key_digit  input  4  BCD digit, 0..9; codes 10..15 are invalid.
REQ-008 commit  input  1  one-cycle request to load the completed entry.
REQ-009 cancel  input  1  one-cycle request to abandon the entry.
REQ-010 H_in1  output  2  committed hour tens digit.
REQ-011 H_in0  output  4  committed hour units digit.
REQ-012 M_in1  output  4  committed minute tens digit.
REQ-013 M_in0  output  4  committed minute units digit.
REQ-014 LD_time  output  1  one-cycle load strobe for current time.
REQ-015 LD_alarm  output  1  one-cycle load strobe for alarm time.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 digit_idx  output  2  index of next expected digit (0 = H1, 1 = H0, 2 = M1, 3 = M0); 0 outside ENTRY.
REQ-018 key_err  output  1  one-cycle pulse on a rejected key or timeout abort.

Function
REQ-019 States: IDLE, ENTRY, READY, LOAD; one-hot or binary encoding is free.
REQ-020 IDLE: start -> ENTRY, mode latched internally, digit_idx = 0, staging digits cleared to 0, timeout counter cleared.
REQ-021 ENTRY: key_valid with an acceptable digit -> digit stored in staging register [digit_idx], digit_idx increments; on the fourth accepted digit -> READY.
REQ-022 Acceptance: idx0 digit <= 2; idx1 digit <= 9, or <= 3 when staged H1 = 2; idx2 digit <= 5; idx3 digit <= 9.
REQ-023 Rejected digit: key_err pulses the next cycle, digit_idx and staging unchanged, state unchanged.
REQ-024 READY: commit -> LOAD; key_valid ignored, no key_err.
REQ-025 LOAD: lasts exactly one cycle; H_in1..M_in0 update from staging on the edge entering LOAD; LD_time (mode 0) or LD_alarm (mode 1) high for exactly that one cycle; next state IDLE.
REQ-026 Outputs H_in1..M_in0 hold the last committed value at all other times; staging values never appear on them before LOAD.
REQ-027 LD_time and LD_alarm never high together; both low outside LOAD.
REQ-028 Timeout counter counts cycles in ENTRY and READY, clears on every key_valid (accepted or rejected); on reaching TIMEOUT_CYCLES -> IDLE with key_err pulse, no load.
REQ-029 cancel in ENTRY or READY -> IDLE next cycle, no load, no key_err; cancel in IDLE or LOAD ignored.
REQ-030 Priority in one cycle: cancel > timeout > commit > key_valid; start ignored outside IDLE; commit ignored outside READY.
REQ-031 All control inputs are synchronous to clk; no internal debouncing.

Reset
REQ-032 reset low asynchronously forces IDLE, H_in1..M_in0 = 0, LD_time = LD_alarm = 0, busy = 0, digit_idx = 0, key_err = 0, timeout counter and staging = 0.
REQ-033 reset asserted mid-entry or during LOAD discards the entry; no load strobe is emitted on or after release.

Verification
REQ-034 start mode=0, keys 1,7,4,5, commit -> one cycle LD_time=1 with H_in1=1, H_in0=7, M_in1=4, M_in0=5; LD_alarm stays 0; busy falls next cycle.
REQ-035 start mode=1, keys 2,4 (rejected, key_err pulse, digit_idx stays 1), 3, 6 (rejected), 5, 9, commit -> LD_alarm pulse with 2,3,5,9.
REQ-036 start, keys 0,8, then no keys for TIMEOUT_CYCLES -> IDLE, key_err pulse, outputs keep prior values, no strobe.
REQ-037 start, four valid keys, cancel and commit same cycle -> IDLE, no strobe, outputs unchanged.
REQ-038 reset low during READY after keys 1,2,3,4 -> all outputs 0 immediately; after release, commit produces no strobe.
